// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the uart frame parser (RX side, reusable on TX).
package uart_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Running checksum is a plain modulo-256 sum.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_frame_tmo.sv
// Inter-byte gap counter: counts idle cycles while armed, flags expiry on the last one.
module uart_frame_tmo #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    logic [GW-1:0] gap_reg, gap_next;

    always_comb begin
        gap_next = gap_reg;
        if (clr) begin
            gap_next = '0;
        end else if (run) begin
            gap_next = gap_reg + GW'(1);
        end
    end

    // Expiry is the cycle that would make the count reach TIMEOUT_CYCLES.
    assign expired = run && !clr && (gap_reg == GW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_reg <= '0;
        end else begin
            gap_reg <= gap_next;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the uart RX FIFO: SOF, LEN, payload, CHK -> valid/ready stream + status pulse.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_rxfifo_ren,
    input  logic       i_rxfifo_empty,
    input  logic [7:0] i_rxfifo_rdata,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_frame_done,
    output logic       o_frame_ok,
    output logic [1:0] o_err_code
);

    state_t     state_reg, state_next;
    logic [7:0] len_reg, len_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] chk_reg, chk_next;
    logic       done_reg, done_next;
    logic       ok_reg, ok_next;
    logic [1:0] err_reg, err_next;

    logic       rxfifo_ren;
    logic       pay_valid;
    logic       pay_last;
    logic       tmo_clr;
    logic       tmo_run;
    logic       tmo_expired;

    assign pay_valid = (state_reg == PAYLOAD) && !i_rxfifo_empty;
    assign pay_last  = pay_valid && (cnt_reg == len_reg - 8'd1);

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        chk_next   = chk_reg;
        done_next  = 1'b0;
        ok_next    = ok_reg;
        err_next   = err_reg;
        rxfifo_ren = 1'b0;

        case (state_reg)
            HUNT: begin
                rxfifo_ren = !i_rxfifo_empty;
                if (rxfifo_ren && (i_rxfifo_rdata == SOF)) begin
                    state_next = LEN;
                    chk_next   = 8'd0;
                end
            end
            LEN: begin
                rxfifo_ren = !i_rxfifo_empty;
                if (rxfifo_ren) begin
                    len_next = i_rxfifo_rdata;
                    cnt_next = 8'd0;
                    chk_next = chk_add(chk_reg, i_rxfifo_rdata);
                    if (i_rxfifo_rdata == 8'd0) begin
                        state_next = CHK;
                    end else if (i_rxfifo_rdata > 8'(MAX_LEN)) begin
                        state_next = HUNT;
                        done_next  = 1'b1;
                        ok_next    = 1'b0;
                        err_next   = ERR_LEN;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end else if (tmo_expired) begin
                    state_next = HUNT;
                    done_next  = 1'b1;
                    ok_next    = 1'b0;
                    err_next   = ERR_TMO;
                end
            end
            PAYLOAD: begin
                rxfifo_ren = !i_rxfifo_empty && i_ready;
                if (rxfifo_ren) begin
                    cnt_next = cnt_reg + 8'd1;
                    chk_next = chk_add(chk_reg, i_rxfifo_rdata);
                    if (pay_last) begin
                        state_next = CHK;
                    end
                end else if (tmo_expired) begin
                    state_next = HUNT;
                    done_next  = 1'b1;
                    ok_next    = 1'b0;
                    err_next   = ERR_TMO;
                end
            end
            CHK: begin
                rxfifo_ren = !i_rxfifo_empty;
                if (rxfifo_ren) begin
                    state_next = HUNT;
                    done_next  = 1'b1;
                    if (chk_add(chk_reg, i_rxfifo_rdata) == 8'd0) begin
                        ok_next  = 1'b1;
                        err_next = ERR_NONE;
                    end else begin
                        ok_next  = 1'b0;
                        err_next = ERR_CHK;
                    end
                end else if (tmo_expired) begin
                    state_next = HUNT;
                    done_next  = 1'b1;
                    ok_next    = 1'b0;
                    err_next   = ERR_TMO;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Gap counter is held clear while hunting, so entering LEN starts it from zero.
    assign tmo_clr = rxfifo_ren || (state_reg == HUNT);
    assign tmo_run = (state_reg != HUNT) && i_rxfifo_empty;

    uart_frame_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .run     (tmo_run),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            len_reg   <= 8'd0;
            cnt_reg   <= 8'd0;
            chk_reg   <= 8'd0;
            done_reg  <= 1'b0;
            ok_reg    <= 1'b0;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            chk_reg   <= chk_next;
            done_reg  <= done_next;
            ok_reg    <= ok_next;
            err_reg   <= err_next;
        end
    end

    // Pop strobe is gated by reset so a non-empty FIFO is never drained while held in reset.
    assign o_rxfifo_ren = rxfifo_ren && rst_n;
    assign o_valid      = pay_valid;
    assign o_data       = pay_valid ? i_rxfifo_rdata : 8'd0;
    assign o_last       = pay_last;
    assign o_frame_done = done_reg;
    assign o_frame_ok   = ok_reg;
    assign o_err_code   = err_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: FIFO model feeding directed and random frames.
module tb_uart_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       ren;
    logic       empty;
    logic [7:0] rdata;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;
    logic       done;
    logic       ok;
    logic [1:0] err;

    uart_frame_rx #(
        .SOF            (8'hA5),
        .MAX_LEN        (64),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_rxfifo_ren   (ren),
        .i_rxfifo_empty (empty),
        .i_rxfifo_rdata (rdata),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_data         (data),
        .o_last         (last),
        .o_frame_done   (done),
        .o_frame_ok     (ok),
        .o_err_code     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_data_q[$];
    bit         exp_last_q[$];
    logic [1:0] exp_stat_q[$];

    int         checks = 0;
    int         errors = 0;
    logic       last_ok = 1'b0;
    logic [1:0] last_err = 2'd0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         last_done_cyc = 0;
    bit         hide_en = 1'b0;
    int         ready_mode = 0;
    int         hide_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic ebeat(input logic [7:0] d, input bit l);
        exp_data_q.push_back(d);
        exp_last_q.push_back(l);
    endtask

    task automatic estat(input logic [1:0] e);
        exp_stat_q.push_back(e);
    endtask

    // One clock: drive at negedge, sample 1ns later, pop the FIFO model on the posedge.
    task automatic cycle();
        bit         hide;
        bit         ren_s;
        logic [7:0] ed;
        bit         el;
        logic [1:0] es;
        hide = 1'b0;
        if (hide_en && hide_run < 3 && $urandom_range(0, 3) == 0) hide = 1'b1;
        hide_run = hide ? hide_run + 1 : 0;
        empty = hide || (fifo_q.size() == 0);
        rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = ($urandom_range(0, 2) != 0);
        endcase
        #1;
        ren_s = ren;
        if (ren_s) chk("ren_while_empty", empty, 0);
        if (valid && ready) begin
            chk("beat_expected", exp_data_q.size() != 0, 1);
            if (exp_data_q.size() != 0) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                chk("beat_data", data, ed);
                chk("beat_last", last, el);
            end
            last_acc_cyc = cyc;
        end else if (!valid) begin
            chk("idle_data", data, 0);
            chk("idle_last", last, 0);
        end
        if (done) begin
            chk("done_expected", exp_stat_q.size() != 0, 1);
            if (exp_stat_q.size() != 0) begin
                es = exp_stat_q.pop_front();
                chk("status_ok", ok, (es == 2'd0));
                chk("status_err", err, es);
                last_ok  = (es == 2'd0);
                last_err = es;
            end
            last_done_cyc = cyc;
            $display("frame status ok=%0d err=%0d at cycle %0d", ok, err, cyc);
        end else begin
            chk("hold_ok", ok, last_ok);
            chk("hold_err", err, last_err);
        end
        @(posedge clk);
        if (ren_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n;
        bit drained;
        n = 0;
        while ((fifo_q.size() != 0 || exp_data_q.size() != 0 || exp_stat_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        drained = (fifo_q.size() == 0 && exp_data_q.size() == 0 && exp_stat_q.size() == 0);
        chk(tag, drained, 1);
        repeat (3) cycle();
    endtask

    // Reference frame built from the framing rules: checksum makes LEN+payload+CHK sum to 0 mod 256.
    task automatic model_frame(input int len, input bit bad, input bit noise);
        logic [7:0] b;
        logic [7:0] sum;
        int         nn;
        if (noise) begin
            nn = $urandom_range(0, 2);
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                push(b);
            end
        end
        push(8'hA5);
        push(8'(len));
        if (len > 64) begin
            estat(2'd2);
        end else begin
            sum = 8'(len);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                push(b);
                sum = sum + b;
                ebeat(b, (i == len - 1));
            end
            b = 8'h00 - sum;
            if (bad) b = b + 8'($urandom_range(1, 255));
            push(b);
            estat(bad ? 2'd1 : 2'd0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        empty = 1'b0;
        rdata = 8'hA5;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ren", ren, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        empty = 1'b1;
        rst_n = 1'b1;

        // Good frame
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
        ebeat(8'h11, 0); ebeat(8'h22, 0); ebeat(8'h33, 1); estat(2'd0);
        run_idle(200, "good_drain");

        // Bad checksum
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h98);
        ebeat(8'h11, 0); ebeat(8'h22, 0); ebeat(8'h33, 1); estat(2'd1);
        run_idle(200, "badchk_drain");

        // Noise then frame
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h7E); push(8'h81);
        ebeat(8'h7E, 1); estat(2'd0);
        run_idle(200, "noise_drain");

        // Length error, then zero-length frame
        push(8'hA5); push(8'h41); estat(2'd2);
        push(8'hA5); push(8'h00); push(8'h00); estat(2'd0);
        run_idle(200, "len_drain");

        // Timeout after one payload byte
        push(8'hA5); push(8'h02); push(8'h11);
        ebeat(8'h11, 0); estat(2'd3);
        run_idle(200, "tmo_drain");
        chk("tmo_latency", last_done_cyc - last_acc_cyc, 21);
        push(8'hA5); push(8'h01); push(8'h7E); push(8'h81);
        ebeat(8'h7E, 1); estat(2'd0);
        run_idle(200, "after_tmo_drain");

        // Backpressure with ready toggling every cycle
        ready_mode = 1;
        model_frame(5, 0, 0);
        run_idle(300, "bp_drain");
        model_frame(3, 1, 0);
        run_idle(300, "bp_bad_drain");
        model_frame(6, 0, 0);
        run_idle(300, "bp_good_drain");

        // Reset in the middle of a payload
        ready_mode = 0;
        model_frame(8, 0, 0);
        n = 0;
        while (exp_data_q.size() > 5 && n < 50) begin
            cycle();
            n++;
        end
        chk("mid_reached", exp_data_q.size() <= 5, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ren", ren, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_last", last, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ok", ok, 0);
        chk("mid_rst_err", err, 0);
        fifo_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        exp_stat_q.delete();
        last_ok  = 1'b0;
        last_err = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_idle(20, "post_rst_quiet");
        model_frame(4, 0, 0);
        run_idle(200, "post_rst_drain");

        // Randomized frames with FIFO bubbles and random backpressure
        hide_en    = 1'b1;
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            model_frame($urandom_range(0, 70), ($urandom_range(0, 3) == 0), 1'b1);
            run_idle(2000, "rand_drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
